// File: rtl/aes_key_sched_if.sv
// -----------------------------------------------------------------------------
// aes_key_sched_if
//   Groups the two buses the key-load sequencer talks to:
//     - key store read port : ks_req_o / ks_addr_o out, ks_rdata_i / ks_valid_i in
//     - peripheral write bus: wr_valid_o / wr_addr_o / wr_data_o out, wr_ready_i in
//   Signal suffixes are from the sequencer's point of view.
//   Modports:
//     master : the sequencer (drives requests, receives data/ready)
//     slave  : the key store + peripheral side
// -----------------------------------------------------------------------------
interface aes_key_sched_if;
    logic        ks_req_o;
    logic [4:0]  ks_addr_o;
    logic [31:0] ks_rdata_i;
    logic        ks_valid_i;
    logic        wr_valid_o;
    logic [63:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        wr_ready_i;

    modport master (
        output ks_req_o, ks_addr_o, wr_valid_o, wr_addr_o, wr_data_o,
        input  ks_rdata_i, ks_valid_i, wr_ready_i
    );

    modport slave (
        input  ks_req_o, ks_addr_o, wr_valid_o, wr_addr_o, wr_data_o,
        output ks_rdata_i, ks_valid_i, wr_ready_i
    );
endinterface

// File: rtl/aes_key_sched.sv
// -----------------------------------------------------------------------------
// aes_key_sched
//   Key-load sequencer. Arbitrates key-load requests from NUM_REQ masters
//   round-robin, checks the winner against the access-control matrix, and for
//   a permitted request copies KEY_WORDS 32-bit words from the key store into
//   the selected slot's registers on the AES peripheral, one word at a time.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i         level request per requester (sampled only in IDLE)
//   key_id_i      requested slot, 2 bits per requester
//   acct_i        permission matrix, bit [r*NUM_KEYS+k] = r may load slot k
//   gnt_o         one-hot grant pulse (CHECK state)
//   done_o        one-hot completion pulse
//   err_o         one-hot denial pulse
//   busy_o        FSM is not in IDLE
//   bus           key store read port + peripheral write bus (master modport)
//
// Configuration macro:
//   AES_KEY_SCHED_SCRUB_EN  when defined, a denied request naming a valid slot
//                           first overwrites that slot with KEY_WORDS zero
//                           words (SCRUB state) before err_o pulses.
//
// All outputs are decoded from registered state only; no input reaches
// ks_req_o or wr_valid_o combinationally.
// -----------------------------------------------------------------------------
module aes_key_sched #(
    parameter int          NUM_REQ   = 3,
    parameter int          NUM_KEYS  = 3,
    parameter int          KEY_WORDS = 6,
    parameter logic [63:0] AES_BASE  = 64'h1010_0000,
    parameter logic [63:0] SLOT0_OFF = 64'h14,
    parameter logic [63:0] SLOT1_OFF = 64'h50,
    parameter logic [63:0] SLOT2_OFF = 64'h68
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [2*NUM_REQ-1:0]         key_id_i,
    input  logic [NUM_REQ*NUM_KEYS-1:0]  acct_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic [NUM_REQ-1:0]           err_o,
    output logic                         busy_o,
    aes_key_sched_if.master              bus
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] LAST_WORD = 3'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR,
        S_SCRUB
    } state_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [1:0]       key_id_q, key_id_d;
    logic [2:0]       word_q,   word_d;
    logic [31:0]      data_q,   data_d;

    // Round-robin pick: first requester at or after rr_ptr_q.
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [1:0]       pick_key;
    int               idx;

    // Permission of the latched winner for the latched slot. Only in-range
    // slots are enumerated, so an out-of-range key_id is never permitted.
    logic             permit;

    function automatic logic [63:0] slot_off(input logic [1:0] k);
        case (k)
            2'd0:    return SLOT0_OFF;
            2'd1:    return SLOT1_OFF;
            default: return SLOT2_OFF;
        endcase
    endfunction

    // Byte address of the current word inside the latched slot.
    logic [63:0] slot_addr;
    assign slot_addr = AES_BASE + slot_off(key_id_q) + {59'd0, word_q, 2'b00};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its _d input regardless of process ordering.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous, so it is just the highest-priority
        // branch of the same clocked process; the data register is a plain
        // flop and is cleared along with the control state.
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            key_id_q <= '0;
            word_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            key_id_q <= key_id_d;
            word_q   <= word_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
        pick_key = key_id_i[2*int'(pick) +: 2];
    end

    always_comb begin
        permit = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (int'(winner_q) == r && int'(key_id_q) == k) begin
                    permit = acct_i[r*NUM_KEYS + k];
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        key_id_d = key_id_q;
        word_d   = word_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    winner_d = pick;
                    key_id_d = pick_key;
                    rr_ptr_d = (int'(pick) == NUM_REQ - 1) ? '0 : pick + IDX_W'(1);
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                word_d = '0;
                if (permit) begin
                    state_d = S_READ;
                end
`ifdef AES_KEY_SCHED_SCRUB_EN
                else if (int'(key_id_q) < NUM_KEYS) begin
                    state_d = S_SCRUB;
                end
`endif
                else begin
                    state_d = S_ERR;
                end
            end
            S_READ: begin
                if (bus.ks_valid_i) begin
                    data_d  = bus.ks_rdata_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.wr_ready_i) begin
                    if (word_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        word_d  = word_q + 3'd1;
                        state_d = S_READ;
                    end
                end
            end
`ifdef AES_KEY_SCHED_SCRUB_EN
            S_SCRUB: begin
                if (bus.wr_ready_i) begin
                    if (word_q == LAST_WORD) begin
                        state_d = S_ERR;
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        gnt_o          = '0;
        done_o         = '0;
        err_o          = '0;
        busy_o         = (state_q != S_IDLE);
        bus.ks_req_o   = 1'b0;
        bus.ks_addr_o  = '0;
        bus.wr_valid_o = 1'b0;
        bus.wr_addr_o  = '0;
        bus.wr_data_o  = '0;

        case (state_q)
            S_CHECK: gnt_o[winner_q] = 1'b1;
            S_READ: begin
                bus.ks_req_o  = 1'b1;
                bus.ks_addr_o = {key_id_q, word_q};
            end
            S_WRITE: begin
                bus.wr_valid_o = 1'b1;
                bus.wr_addr_o  = slot_addr;
                bus.wr_data_o  = data_q;
            end
            S_SCRUB: begin
                // Zero data; unreachable unless the scrub feature is built in.
                bus.wr_valid_o = 1'b1;
                bus.wr_addr_o  = slot_addr;
            end
            S_DONE:  done_o[winner_q] = 1'b1;
            S_ERR:   err_o[winner_q]  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched
//   Scoreboard bench for aes_key_sched. The driver pushes the expected grant,
//   bus writes and completion/denial event for every request it issues; an
//   independent monitor pops and compares whenever the DUT presents one.
//   Expected values come from a slot/permission model of the key-load rules.
// -----------------------------------------------------------------------------
module tb_aes_key_sched;

    localparam logic [63:0] BASE = 64'h1010_0000;

    typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit is_err; logic [2:0] who; int cyc; } evt_t;
    typedef struct { logic [2:0] who; int cyc; } gnt_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  req_i;
    logic [5:0]  key_id_i;
    logic [8:0]  acct_i;
    logic [2:0]  gnt_o, done_o, err_o;
    logic        busy_o;

    aes_key_sched_if bus ();

    aes_key_sched dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .key_id_i (key_id_i),
        .acct_i   (acct_i),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Key store and peripheral models.
    logic [31:0] ks_mem [32];
    bit          ks_en    = 1'b1;
    bit          ready_en = 1'b1;
    bit          rand_bus = 1'b0;
    logic [63:0] stall_addr = '0;
    int          stall_left = 0;

    assign bus.ks_valid_i = bus.ks_req_o & ks_en;
    assign bus.ks_rdata_i = ks_mem[bus.ks_addr_o];
    assign bus.wr_ready_i = bus.wr_valid_o & ready_en &
                            !(stall_left != 0 && bus.wr_addr_o == stall_addr);

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rr_m = 0;

    wr_t  exp_wr  [$];
    evt_t exp_evt [$];
    gnt_t exp_gnt [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] slot_base(input int k);
        case (k)
            0:       return BASE + 64'h14;
            1:       return BASE + 64'h50;
            default: return BASE + 64'h68;
        endcase
    endfunction

    function automatic bit allowed(input int r, input int k, input logic [8:0] acct);
        if (k >= 3) return 1'b0;
        return acct[r*3 + k];
    endfunction

    // Round-robin model: first set bit at or after the pointer wins.
    function automatic int arb(input logic [2:0] mask);
        for (int i = 0; i < 3; i++) begin
            int j;
            j = (rr_m + i) % 3;
            if (mask[j]) begin
                rr_m = (j + 1) % 3;
                return j;
            end
        end
        return -1;
    endfunction

    // Cycles from request to done_o/err_o with a zero-wait store and bus.
    function automatic int latency(input int r, input int k, input logic [8:0] acct);
        if (allowed(r, k, acct)) return 2 + 2*6;
`ifdef AES_KEY_SCHED_SCRUB_EN
        if (k < 3) return 2 + 6;
`endif
        return 2;
    endfunction

    task automatic push_transfer(input int r, input int k, input logic [8:0] acct, input int evt_cyc);
        evt_t e;
        if (allowed(r, k, acct)) begin
            for (int w = 0; w < 6; w++)
                exp_wr.push_back('{slot_base(k) + 64'(4*w), ks_mem[k*8 + w]});
        end
`ifdef AES_KEY_SCHED_SCRUB_EN
        else if (k < 3) begin
            for (int w = 0; w < 6; w++)
                exp_wr.push_back('{slot_base(k) + 64'(4*w), 32'd0});
        end
`endif
        e.is_err = !allowed(r, k, acct);
        e.who    = 3'(1 << r);
        e.cyc    = evt_cyc;
        exp_evt.push_back(e);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},      64'(gnt_o), 64'd0);
        check({tag, "_done"},     64'(done_o), 64'd0);
        check({tag, "_err"},      64'(err_o), 64'd0);
        check({tag, "_busy"},     64'(busy_o), 64'd0);
        check({tag, "_ks_req"},   64'(bus.ks_req_o), 64'd0);
        check({tag, "_ks_addr"},  64'(bus.ks_addr_o), 64'd0);
        check({tag, "_wr_valid"}, 64'(bus.wr_valid_o), 64'd0);
        check({tag, "_wr_addr"},  bus.wr_addr_o, 64'd0);
        check({tag, "_wr_data"},  64'(bus.wr_data_o), 64'd0);
    endtask

    // Single request from an idle DUT; called just after a rising edge.
    task automatic issue_one(input int r, input int k, input logic [8:0] acct,
                             input bit timed, input int extra);
        int c;
        bit got;
        c = cyc;
        key_id_i[2*r +: 2] = 2'(k);
        acct_i = acct;
        exp_gnt.push_back('{3'(1 << r), c + 1});
        push_transfer(r, k, acct, timed ? c + latency(r, k, acct) + extra : -1);
        void'(arb(3'(1 << r)));
        req_i[r] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((done_o[r] | err_o[r]) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("resp_timeout_r%0d_k%0d", r, k), 64'(got), 64'd1);
        req_i[r] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus wait-state generator.
    initial forever begin
        @(posedge clk); #1;
        if (rand_bus) begin
            ks_en    = ($urandom_range(0, 9) < 7);
            ready_en = ($urandom_range(0, 9) < 7);
        end else begin
            ks_en    = 1'b1;
            ready_en = 1'b1;
        end
    end

    // Counts cycles in which the stall address was held off.
    initial forever begin
        bit blk;
        @(negedge clk);
        blk = bus.wr_valid_o && bus.wr_addr_o == stall_addr && stall_left != 0;
        @(posedge clk); #1;
        if (blk && stall_left > 0) stall_left--;
    end

    // Monitor / scoreboard.
    initial begin
        bit          pend = 1'b0;
        logic [63:0] p_addr = '0;
        logic [31:0] p_data = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pend = 1'b0;
                continue;
            end
            if (gnt_o != 3'b000) begin
                if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(gnt_o), 64'd0);
                else begin
                    gnt_t g;
                    g = exp_gnt.pop_front();
                    check("gnt_who", 64'(gnt_o), 64'(g.who));
                    if (g.cyc >= 0) check("gnt_cycle", 64'(cyc), 64'(g.cyc));
                end
            end
            if ((done_o | err_o) != 3'b000) begin
                if (exp_evt.size() == 0) begin
                    check("done_unexpected", 64'(done_o), 64'd0);
                    check("err_unexpected", 64'(err_o), 64'd0);
                end else begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    check("evt_done", 64'(done_o), e.is_err ? 64'd0 : 64'(e.who));
                    check("evt_err",  64'(err_o),  e.is_err ? 64'(e.who) : 64'd0);
                    if (e.cyc >= 0) check("evt_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (pend) begin
                check("wr_hold_valid", 64'(bus.wr_valid_o), 64'd1);
                check("wr_hold_addr",  bus.wr_addr_o, p_addr);
                check("wr_hold_data",  64'(bus.wr_data_o), 64'(p_data));
            end
            if (bus.wr_valid_o && bus.wr_ready_i) begin
                if (exp_wr.size() == 0) check("wr_unexpected", bus.wr_addr_o, 64'd0);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", bus.wr_addr_o, w.addr);
                    check("wr_data", 64'(bus.wr_data_o), 64'(w.data));
                end
            end
            pend   = bus.wr_valid_o && !bus.wr_ready_i;
            p_addr = bus.wr_addr_o;
            p_data = bus.wr_data_o;
        end
    end

    // Stimulus.
    initial begin
        int c;
        int n;
        int rk [3];
        bit got;

        for (int i = 0; i < 32; i++) ks_mem[i] = $urandom;

        // All three requesters held high out of reset.
        rk[0] = 1; rk[1] = 0; rk[2] = 2;
        rst_i    = 1'b1;
        req_i    = 3'b111;
        key_id_i = {2'(rk[2]), 2'(rk[1]), 2'(rk[0])};
        acct_i   = 9'h1FF;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");

        c = cyc;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = arb(3'b111);
            exp_gnt.push_back('{3'(1 << w), c + 1 + 15*i});
            push_transfer(w, rk[w], 9'h1FF, c + 14 + 15*i);
        end
        rst_i = 1'b0;
        n = 0;
        for (int i = 0; i < 2000 && n < 4; i++) begin
            @(negedge clk);
            if ((done_o | err_o) != 3'b000) n++;
        end
        req_i = 3'b000;
        check("rr_timeout", 64'(n), 64'd4);
        @(posedge clk); #1;

        // Requester 0, key 1, permitted.
        issue_one(0, 1, 9'h1FF, 1'b1, 0);
        // Requester 2, key 0, acct bit 6 clear.
        issue_one(2, 0, 9'h1BF, 1'b1, 0);
        // Requester 1, out-of-range key.
        issue_one(1, 3, 9'h1FF, 1'b1, 0);
        // Requester 1, key 2, five-cycle stall on word 3.
        stall_addr = slot_base(2) + 64'd12;
        stall_left = 5;
        issue_one(1, 2, 9'h1FF, 1'b1, 5);
        stall_left = 0;

        // Reset while word 2 is on the bus.
        c = cyc;
        key_id_i[5:4] = 2'd0;
        acct_i = 9'h1FF;
        exp_gnt.push_back('{3'b100, c + 1});
        push_transfer(2, 0, 9'h1FF, -1);
        void'(arb(3'b100));
        stall_addr = slot_base(0) + 64'd8;
        stall_left = 1000;
        req_i[2] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.wr_valid_o && bus.wr_addr_o == stall_addr) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_reach_word2", 64'(got), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_quiet("midreset");
        rst_i      = 1'b0;
        req_i      = 3'b000;
        stall_left = 0;
        exp_wr.delete();
        exp_evt.delete();
        exp_gnt.delete();
        rr_m = 0;
        @(posedge clk); #1;

        // Randomized single requests with random wait states.
        rand_bus = 1'b1;
        for (int i = 0; i < 40; i++) begin
            key_id_i = 6'($urandom);
            issue_one($urandom_range(0, 2), $urandom_range(0, 3), 9'($urandom), 1'b0, 0);
        end
        rand_bus = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("end_wr_queue",  64'(exp_wr.size()), 64'd0);
        check("end_evt_queue", 64'(exp_evt.size()), 64'd0);
        check("end_gnt_queue", 64'(exp_gnt.size()), 64'd0);
        check("end_busy",      64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
